// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned load shadowing.
// Optional leading-zero suppression: define SEGSCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    segclk,
    input  logic                    clr_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    busy,
    output logic                    frame_start
);

    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic          POL  = (ACTIVE_LOW != 0);
    localparam logic          INV  = ~POL;

    logic [PW-1:0]           r_pre;
    logic [CW-1:0]           r_cur;
    logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_act_blank;
    logic                    r_busy;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_fs;

    logic                    w_tick, w_fs_tick, w_xfer;
    logic [4*NUM_DIGITS-1:0] w_src_data, w_nxt_data;
    logic [NUM_DIGITS-1:0]   w_src_dp, w_src_blank, w_nxt_dp, w_nxt_blank, w_lz;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg_raw;
    logic                    w_dp_raw;
    logic [NUM_DIGITS-1:0]   w_an_raw;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    assign w_tick    = (r_pre == PMAX);
    assign w_fs_tick = w_tick && (r_cur == LAST);
    // A load on the frame-start edge bypasses pending and lands in active directly.
    assign w_xfer    = w_fs_tick && (load || r_busy);

    assign w_src_data  = load ? data  : r_pend_data;
    assign w_src_dp    = load ? dp_in : r_pend_dp;
    assign w_src_blank = load ? blank : r_pend_blank;

`ifdef SEGSCAN_LEADING_ZERO_BLANK_EN
    always_comb begin
        w_lz = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            w_lz[i] = ((w_src_data >> (4 * i)) == '0);
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_nxt_data  = w_xfer ? w_src_data : r_act_data;
    assign w_nxt_dp    = w_xfer ? w_src_dp : r_act_dp;
    assign w_nxt_blank = w_xfer ? (w_src_blank | w_lz) : r_act_blank;

    assign w_nib     = w_nxt_data[{r_cur, 2'b00} +: 4];
    assign w_seg_raw = w_nxt_blank[r_cur] ? 7'b1111111 : f_decode(w_nib);
    assign w_dp_raw  = w_nxt_blank[r_cur] | ~w_nxt_dp[r_cur];

    always_comb begin
        w_an_raw        = '1;
        w_an_raw[r_cur] = 1'b0;
    end

    always_ff @(posedge segclk or negedge clr_n) begin
        if (!clr_n) begin
            r_pre        <= '0;
            r_cur        <= LAST;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_busy       <= 1'b0;
            r_seg        <= {7{POL}};
            r_dp         <= POL;
            r_an         <= {NUM_DIGITS{POL}};
            r_fs         <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            r_fs  <= w_fs_tick;
            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank;
            end
            if (w_xfer) begin
                r_busy <= 1'b0;
            end else if (load) begin
                r_busy <= 1'b1;
            end
            if (w_tick) begin
                r_cur       <= (r_cur == '0) ? LAST : r_cur - 1'b1;
                r_act_data  <= w_nxt_data;
                r_act_dp    <= w_nxt_dp;
                r_act_blank <= w_nxt_blank;
                r_seg       <= w_seg_raw ^ {7{INV}};
                r_dp        <= w_dp_raw ^ INV;
                r_an        <= w_an_raw ^ {NUM_DIGITS{INV}};
            end
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign busy        = r_busy;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two configurations checked every cycle against a frame-level model.
module tb_seg_scan_mux;

    logic        clk      = 1'b0;
    logic        clr_n    = 1'b0;
    logic        load     = 1'b0;
    logic [31:0] data_bus = '0;
    logic [7:0]  dp_bus   = '0;
    logic [7:0]  bl_bus   = '0;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1, busy0, busy1, fs0, fs1;
    logic [3:0] an0;
    logic [7:0] an1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(1), .ACTIVE_LOW(1)) u0 (
        .segclk(clk), .clr_n(clr_n), .load(load), .data(data_bus[15:0]),
        .dp_in(dp_bus[3:0]), .blank(bl_bus[3:0]), .seg(seg0), .dp(dp0),
        .an(an0), .busy(busy0), .frame_start(fs0)
    );

    seg_scan_mux #(.NUM_DIGITS(8), .SCAN_DIV(3), .ACTIVE_LOW(0)) u1 (
        .segclk(clk), .clr_n(clr_n), .load(load), .data(data_bus),
        .dp_in(dp_bus), .blank(bl_bus), .seg(seg1), .dp(dp1),
        .an(an1), .busy(busy1), .frame_start(fs1)
    );

    logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model: edge count since reset gives the slot; each frame shows the last load made
    // at or before its first edge.
    int          m_cyc   [2];
    bit          m_pend  [2];
    logic [31:0] m_ld_d  [2];
    logic [31:0] m_fr_d  [2];
    logic [7:0]  m_ld_dp [2];
    logic [7:0]  m_ld_bl [2];
    logic [7:0]  m_fr_dp [2];
    logic [7:0]  m_fr_bl [2];
    logic [6:0]  e_seg   [2];
    logic        e_dp    [2];
    logic [7:0]  e_an    [2];
    logic        e_busy  [2];
    logic        e_fs    [2];

    function automatic logic [7:0] dmask(input int n);
        logic [15:0] t;
        t = (16'd1 << n) - 16'd1;
        return t[7:0];
    endfunction

    task automatic mdl_reset(input int j, input int n, input bit al);
        m_cyc[j]   = 0;
        m_pend[j]  = 1'b0;
        m_ld_d[j]  = '0;
        m_ld_dp[j] = '0;
        m_ld_bl[j] = '0;
        m_fr_d[j]  = '0;
        m_fr_dp[j] = '0;
        m_fr_bl[j] = dmask(n);
        e_seg[j]   = al ? 7'h7F : 7'h00;
        e_dp[j]    = al;
        e_an[j]    = al ? dmask(n) : 8'h00;
        e_busy[j]  = 1'b0;
        e_fs[j]    = 1'b0;
    endtask

    task automatic mdl_edge(input int j, input int n, input int s, input bit al);
        int k, dig;
        logic [6:0] raw;
        logic rdp;
        if (load) begin
            m_ld_d[j]  = data_bus;
            m_ld_dp[j] = dp_bus;
            m_ld_bl[j] = bl_bus;
            m_pend[j]  = 1'b1;
        end
        m_cyc[j]++;
        e_fs[j] = 1'b0;
        if (m_cyc[j] % s == 0) begin
            k   = m_cyc[j] / s - 1;
            dig = n - 1 - (k % n);
            if (k % n == 0) begin
                e_fs[j] = 1'b1;
                if (m_pend[j]) begin
                    m_fr_d[j]  = m_ld_d[j];
                    m_fr_dp[j] = m_ld_dp[j];
                    m_fr_bl[j] = m_ld_bl[j] & dmask(n);
`ifdef SEGSCAN_LEADING_ZERO_BLANK_EN
                    begin
                        longint unsigned v;
                        v = {32'd0, m_ld_d[j]} & ((64'd1 << (4 * n)) - 64'd1);
                        for (int i = 1; i < n; i++)
                            if ((v >> (4 * i)) == 0) m_fr_bl[j][i] = 1'b1;
                    end
`endif
                    m_pend[j] = 1'b0;
                end
            end
            raw      = m_fr_bl[j][dig] ? 7'h7F : HEX[m_fr_d[j][4*dig +: 4]];
            rdp      = m_fr_bl[j][dig] | ~m_fr_dp[j][dig];
            e_seg[j] = al ? raw : ~raw;
            e_dp[j]  = al ? rdp : ~rdp;
            e_an[j]  = al ? (dmask(n) & ~(8'd1 << dig)) : (8'd1 << dig);
        end
        e_busy[j] = m_pend[j];
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mdl_reset(0, 4, 1'b1);
            mdl_reset(1, 8, 1'b0);
        end else begin
            mdl_edge(0, 4, 1, 1'b1);
            mdl_edge(1, 8, 3, 1'b0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("seg0",  32'(seg0),  32'(e_seg[0]));
        chk("dp0",   32'(dp0),   32'(e_dp[0]));
        chk("an0",   32'(an0),   32'(e_an[0][3:0]));
        chk("busy0", 32'(busy0), 32'(e_busy[0]));
        chk("fs0",   32'(fs0),   32'(e_fs[0]));
        chk("seg1",  32'(seg1),  32'(e_seg[1]));
        chk("dp1",   32'(dp1),   32'(e_dp[1]));
        chk("an1",   32'(an1),   32'(e_an[1]));
        chk("busy1", 32'(busy1), 32'(e_busy[1]));
        chk("fs1",   32'(fs1),   32'(e_fs[1]));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] A0 [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] A1 [4] = '{8'h00, 8'h00, 8'h80, 8'h80};
    logic       F0 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        step(3);
        #2 clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("pin_an0",  32'(an0),  32'(A0[i]));
            chk("pin_seg0", 32'(seg0), 32'h7F);
            chk("pin_fs0",  32'(fs0),  32'(F0[i]));
            chk("pin_an1",  32'(an1),  32'(A1[i]));
        end
        step(1);
        load = 1'b1; data_bus = 32'h0000_1A8F; dp_bus = 8'h04; bl_bus = 8'h00;
        step(1);
        load = 1'b0;
        chk("pin_busy_set", 32'(busy0), 32'd1);
        step(2);
        chk("pin_busy_hold", 32'(busy0), 32'd1);
        step(1);
        chk("pin_1a8f_d3", 32'(seg0), 32'b1111001);
        chk("pin_1a8f_an", 32'(an0), 32'b0111);
        chk("pin_1a8f_dp3", 32'(dp0), 32'd1);
        chk("pin_busy_clr", 32'(busy0), 32'd0);
        step(1);
        chk("pin_1a8f_d2", 32'(seg0), 32'b0001000);
        chk("pin_1a8f_dp2", 32'(dp0), 32'd0);
        step(1);
        chk("pin_1a8f_d1", 32'(seg0), 32'b0000000);
        chk("pin_1a8f_dp1", 32'(dp0), 32'd1);
        step(1);
        chk("pin_1a8f_d0", 32'(seg0), 32'b0001110);
        step(1);
        load = 1'b1; data_bus = 32'h0000_1111;
        step(1);
        data_bus = 32'h0000_2222;
        step(1);
        load = 1'b0;
        chk("pin_two_busy", 32'(busy0), 32'd1);
        step(2);
        chk("pin_two_2222", 32'(seg0), 32'b0100100);
        chk("pin_two_clr", 32'(busy0), 32'd0);
        step(3);
        load = 1'b1; data_bus = 32'h0000_3333;
        step(1);
        load = 1'b0;
        chk("pin_coin_busy", 32'(busy0), 32'd0);
        chk("pin_coin_seg", 32'(seg0), 32'b0110000);
        chk("pin_coin_an", 32'(an0), 32'b0111);
`ifdef SEGSCAN_LEADING_ZERO_BLANK_EN
        step(3);
        load = 1'b1; data_bus = 32'h0000_0040;
        step(1);
        load = 1'b0;
        chk("pin_lz_d3", 32'(seg0), 32'h7F);
        step(1);
        chk("pin_lz_d2", 32'(seg0), 32'h7F);
        step(1);
        chk("pin_lz_d1", 32'(seg0), 32'b0011001);
        step(1);
        chk("pin_lz_d0", 32'(seg0), 32'b1000000);
`endif
        repeat (600) begin
            step(1);
            load     = ($urandom_range(0, 3) == 0);
            data_bus = $urandom;
            dp_bus   = 8'($urandom);
            bl_bus   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        end
        step(1);
        load = 1'b1; data_bus = $urandom; bl_bus = 8'h00;
        step(1);
        load = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        chk("rst_seg0",  32'(seg0),  32'h7F);
        chk("rst_an0",   32'(an0),   32'hF);
        chk("rst_dp0",   32'(dp0),   32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_fs0",   32'(fs0),   32'd0);
        chk("rst_seg1",  32'(seg1),  32'h00);
        chk("rst_an1",   32'(an1),   32'h00);
        chk("rst_dp1",   32'(dp1),   32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        step(2);
        #2 clr_n = 1'b1;
        step(60);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexer for common-anode 7-segment displays. It time-multiplexes `NUM_DIGITS` hex digits onto a shared segment bus. Each digit decodes a 4-bit value with its own decimal point and blank control. A load handshake with frame-boundary shadowing keeps a new value from tearing on screen. The block sits between the scan-clock source and the board display pins, and is the general successor to the fixed four-letter display driver.

## Interface
- `NUM_DIGITS`, 4: digits scanned, legal 1..8.
- `SCAN_DIV`, 1: `segclk` cycles per digit slot, legal ≥1; 1 advances every cycle.
- `ACTIVE_LOW`, 1: 1 = segments/dp/anodes low-active (board default); 0 = all three inverted.
- `segclk`  in  1  scan clock, all state on rising edge.
- `clr_n`  in  1  reset: asynchronous, active-low.
- `load`  in  1  one-cycle strobe capturing `data`/`dp_in`/`blank` into the pending register.
- `data`  in  4*NUM_DIGITS  hex nibble per digit; nibble i drives digit i, where digit 0 is rightmost.
- `dp_in`  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- `blank`  in  NUM_DIGITS  1 = digit dark (anode still scanned, segments and dp off).
- `seg`  out  7  {g,f,e,d,c,b,a}, registered.
- `dp`  out  1  decimal point, registered.
- `an`  out  NUM_DIGITS  anode enables, one-hot active, registered.
- `busy`  out  1  pending load not yet applied.
- `frame_start`  out  1  one-cycle pulse when the leftmost digit is driven.

## Operation
- `tick` asserts when the prescaler reaches `SCAN_DIV-1`; the prescaler then wraps to 0. With `SCAN_DIV`=1, `tick`=1 every cycle.
- Scan index `cur` runs `NUM_DIGITS-1` → 0, then back to `NUM_DIGITS-1`, matching left-to-right scan order.
- On each `tick`:
  - `an` selects digit `cur` only;
  - `seg`/`dp` take the decode of the active register at `cur`;
  - `cur` steps to the next digit.
- Decode (low-active, pre-polarity):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanked digit: `seg`=1111111 and `dp`=1 (low-active); `an` still asserted for that slot.
- Load handshake:
  - `load` copies the inputs to pending and sets `busy`.
  - On the next `tick` that drives digit `NUM_DIGITS-1`, pending moves to active before decode, so that whole frame uses the new data. `busy` clears on the same edge.
  - `load` while `busy`: pending is overwritten (last wins) and `busy` stays 1.
  - `load` on the same edge as a frame-start `tick`: the loaded inputs go straight to active for that frame and `busy` stays 0.
- `ACTIVE_LOW`=0 inverts `seg`, `dp` and `an` at the output registers only.

## Timing
- Reset (`clr_n`=0, asynchronous), with values shown for `ACTIVE_LOW`=1:
  - `seg`=1111111, `dp`=1, `an`=all ones;
  - `busy`=0, `frame_start`=0;
  - `cur`=`NUM_DIGITS-1`, prescaler=0;
  - active and pending data=0, active `blank`=all ones.
- Reset mid-load discards pending data.
- The first `tick` after reset release drives the leftmost digit and pulses `frame_start`.
- Outputs change only on `tick` edges and hold between them.
- A full frame is `NUM_DIGITS*SCAN_DIV` cycles.
- Load-to-display latency: 1 to `NUM_DIGITS*SCAN_DIV` cycles.
- With `NUM_DIGITS`=1, every `tick` is a frame start.

## Configuration
- `SEGSCAN_LEADING_ZERO_BLANK_EN` defined: at transfer to active, any digit whose nibble is 0 and whose higher digits are all also 0 is forced blank. Digit 0 is never suppressed, so value 0 shows one "0". An explicit `blank` is ORed with the forced blank.
- Macro undefined: only `blank` controls darkness, and zeros display normally.

## Test plan
- Reset, then 4 ticks with no load → `an` walks 0111, 1011, 1101, 1110; `seg`=1111111 each slot; `frame_start` high on the 0111 slot only.
- `NUM_DIGITS`=4, `SCAN_DIV`=1, load `data`=16'h1A8F, `dp_in`=0100, `blank`=0 → next frame shows seg 1111001 / 0001000 / 0000000 / 0001110, `dp`=0 on the 1011 slot only; `busy` 1→0 at frame start.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 is displayed; 1111 never appears; `busy` stays high throughout.
- `load` coincident with frame-start `tick` → new data visible in that same frame, `busy` never rises.
- `SCAN_DIV`=3, `NUM_DIGITS`=8, `ACTIVE_LOW`=0 → each `an` value held exactly 3 cycles, frame length 24, `an` one-hot high; drop `clr_n` mid-frame → outputs return to reset state at once.
- Macro defined, load 16'h0040 → digits 3 and 2 blank, then "4", "0"; load 16'h0000 → only digit 0 lit, showing 1000000.
